// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent optimizer: FSM state encoding
// and two's-complement saturation limits for any width up to SAT_W bits.
package gd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } gd_state_e;

  localparam int unsigned SAT_W = 64;

  // Largest positive value of a w-bit signed number (truncate to w bits at use).
  function automatic logic [SAT_W-1:0] sat_max(input int unsigned w);
    sat_max = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  // Most negative value of a w-bit signed number (truncate to w bits at use).
  function automatic logic [SAT_W-1:0] sat_min(input int unsigned w);
    sat_min = SAT_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/gd_step_unit.sv
// Combinational step datapath: damps the evaluator step by an arithmetic right
// shift, flags when its magnitude falls below epsilon, and forms the next x as
// a saturating subtract.
// Ports:
//   x_cur       current x (signed)
//   step        learning-rate-scaled gradient from the evaluator (signed)
//   shift       damping shift amount
//   epsilon     convergence threshold (non-negative)
//   scaled_c    step >>> shift
//   below_eps_c |scaled_c| < epsilon
//   x_next_c    x_cur - scaled_c, saturated to the signed DATA_W range
module gd_step_unit
  import gd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic [DATA_W-1:0]  x_cur,
  input  logic [DATA_W-1:0]  step,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [DATA_W-1:0]  epsilon,
  output logic [DATA_W-1:0]  scaled_c,
  output logic               below_eps_c,
  output logic [DATA_W-1:0]  x_next_c
);

  localparam int unsigned EXT_W = DATA_W + 1;
  localparam logic [EXT_W-1:0] X_MAX_EXT = {1'b0, DATA_W'(sat_max(DATA_W))};
  localparam logic [EXT_W-1:0] X_MIN_EXT = {1'b1, DATA_W'(sat_min(DATA_W))};

  logic signed [EXT_W-1:0] scaled_ext;
  logic signed [EXT_W-1:0] mag;
  logic signed [EXT_W-1:0] diff;

  // One extra bit keeps |most negative| and the raw difference exact.
  always_comb begin
    scaled_c    = DATA_W'($signed(step) >>> shift);
    scaled_ext  = {scaled_c[DATA_W-1], scaled_c};
    mag         = scaled_c[DATA_W-1] ? -scaled_ext : scaled_ext;
    below_eps_c = $unsigned(mag) < {1'b0, epsilon};
    diff        = {x_cur[DATA_W-1], x_cur} - scaled_ext;
    if (diff > $signed(X_MAX_EXT)) begin
      x_next_c = X_MAX_EXT[DATA_W-1:0];
    end else if (diff < $signed(X_MIN_EXT)) begin
      x_next_c = X_MIN_EXT[DATA_W-1:0];
    end else begin
      x_next_c = diff[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/gd_optimizer.sv
// Iterative gradient-descent controller. Each iteration asks an external
// evaluator for f(x) and a scaled gradient, tracks the best point seen, damps
// the step whenever an iteration fails to improve, and stops on convergence,
// iteration limit or abort.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_op              level start request (held until done_op is seen)
//   abort                 terminate an operation in EVAL/UPDATE
//   x_init, max_iter,     operation arguments, captured at start
//   epsilon
//   eval_req, eval_x      evaluator request and point to evaluate
//   eval_ack, eval_value, evaluator response
//   eval_step
//   x_at_min, y_min       best point and value found
//   iter_used, converged  iteration count and convergence flag
//   busy, done_op         operation status
module gd_optimizer
  import gd_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned VAL_W     = 64,
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned SHIFT_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_op,
  input  logic              abort,
  input  logic [DATA_W-1:0] x_init,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [DATA_W-1:0] epsilon,
  output logic              eval_req,
  output logic [DATA_W-1:0] eval_x,
  input  logic              eval_ack,
  input  logic [VAL_W-1:0]  eval_value,
  input  logic [DATA_W-1:0] eval_step,
  output logic [DATA_W-1:0] x_at_min,
  output logic [VAL_W-1:0]  y_min,
  output logic [ITER_W-1:0] iter_used,
  output logic              converged,
  output logic              busy,
  output logic              done_op
);

  localparam int unsigned SHIFT_W = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1;
  localparam int unsigned CNT_W   = ITER_W + 1;
  localparam logic [VAL_W-1:0]   Y_INIT    = VAL_W'(sat_max(VAL_W));
  localparam logic [SHIFT_W-1:0] SHIFT_TOP = SHIFT_W'(SHIFT_MAX);

  // Fixed-point format only matters to the evaluator; reject impossible widths.
  if (FRAC_W >= DATA_W) begin : g_frac_chk
    $error("gd_optimizer: FRAC_W must be smaller than DATA_W");
  end

  gd_state_e state_q, state_d;

  logic [DATA_W-1:0]  x_cur_q;
  logic [DATA_W-1:0]  eps_q;
  logic [ITER_W-1:0]  max_iter_q;
  logic [VAL_W-1:0]   val_q;
  logic [DATA_W-1:0]  step_q;
  logic [SHIFT_W-1:0] shift_q;

  logic               eval_req_d;
  logic               busy_d;
  logic               done_op_d;

  logic [DATA_W-1:0]  scaled_c;
  logic               below_eps_c;
  logic [DATA_W-1:0]  x_next_c;
  logic [ITER_W-1:0]  max_eff_c;
  logic               last_iter_c;
  logic               improved_c;

  assign eval_x = x_cur_q;

  gd_step_unit #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_step (
    .x_cur       (x_cur_q),
    .step        (step_q),
    .shift       (shift_q),
    .epsilon     (eps_q),
    .scaled_c    (scaled_c),
    .below_eps_c (below_eps_c),
    .x_next_c    (x_next_c)
  );

  // Iteration-limit and improvement decisions for the UPDATE cycle.
  always_comb begin
    max_eff_c   = (max_iter_q == '0) ? ITER_W'(1) : max_iter_q;
    last_iter_c = ({1'b0, iter_used} + CNT_W'(1)) >= {1'b0, max_eff_c};
    improved_c  = $signed(val_q) < $signed(y_min);
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      eval_req <= 1'b0;
      busy     <= 1'b0;
      done_op  <= 1'b0;
    end else begin
      state_q  <= state_d;
      eval_req <= eval_req_d;
      busy     <= busy_d;
      done_op  <= done_op_d;
    end
  end

  // Next-state logic; abort wins over every other transition in EVAL/UPDATE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_op) state_d = ST_EVAL;
      ST_EVAL: begin
        if (abort)         state_d = ST_DONE;
        else if (eval_ack) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (abort || below_eps_c || last_iter_c) state_d = ST_DONE;
        else                                     state_d = ST_EVAL;
      end
      ST_DONE:   if (!start_op) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step.
  always_comb begin
    eval_req_d = 1'b0;
    busy_d     = 1'b0;
    done_op_d  = 1'b0;
    unique case (state_d)
      ST_EVAL:   begin eval_req_d = 1'b1; busy_d = 1'b1; end
      ST_UPDATE: busy_d    = 1'b1;
      ST_DONE:   done_op_d = 1'b1;
      default:   ;
    endcase
  end

  // Operation datapath: argument capture, response capture, iteration update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cur_q    <= '0;
      x_at_min   <= '0;
      y_min      <= '0;
      iter_used  <= '0;
      shift_q    <= '0;
      converged  <= 1'b0;
      eps_q      <= '0;
      max_iter_q <= '0;
      val_q      <= '0;
      step_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_op) begin
            x_cur_q    <= x_init;
            x_at_min   <= x_init;
            y_min      <= Y_INIT;
            iter_used  <= '0;
            shift_q    <= '0;
            converged  <= 1'b0;
            eps_q      <= epsilon;
            max_iter_q <= max_iter;
          end
        end
        ST_EVAL: begin
          if (!abort && eval_ack) begin
            val_q  <= eval_value;
            step_q <= eval_step;
          end
        end
        ST_UPDATE: begin
          if (!abort) begin
            if (improved_c) begin
              y_min    <= val_q;
              x_at_min <= x_cur_q;
            end else if (iter_used != '0 && shift_q != SHIFT_TOP) begin
              shift_q <= shift_q + SHIFT_W'(1);
            end
            iter_used <= iter_used + ITER_W'(1);
            if (below_eps_c) begin
              converged <= 1'b1;
            end else if (!last_iter_c) begin
              x_cur_q <= x_next_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_optimizer.sv
// Self-checking bench for gd_optimizer. A behavioural model of the descent
// algorithm predicts the sequence of requested points and the final results;
// these go to scoreboard queues and are popped as the DUT issues requests and
// finishes. Inputs change and outputs are sampled on the falling clock edge.
module tb_gd_optimizer;

  localparam logic [63:0] VMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [31:0] x_at_min;
    logic [63:0] y_min;
    logic [7:0]  iter_used;
    logic        converged;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_op = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] x_init = '0;
  logic [7:0]  max_iter = '0;
  logic [31:0] epsilon = '0;
  logic        eval_req;
  logic [31:0] eval_x;
  logic        eval_ack = 1'b0;
  logic [63:0] eval_value = '0;
  logic [31:0] eval_step = '0;
  logic [31:0] x_at_min;
  logic [63:0] y_min;
  logic [7:0]  iter_used;
  logic        converged;
  logic        busy;
  logic        done_op;

  logic [31:0] exp_x_q[$];
  res_t        exp_res_q[$];
  logic [31:0] obs_x_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  gd_optimizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_op   (start_op),
    .abort      (abort),
    .x_init     (x_init),
    .max_iter   (max_iter),
    .epsilon    (epsilon),
    .eval_req   (eval_req),
    .eval_x     (eval_x),
    .eval_ack   (eval_ack),
    .eval_value (eval_value),
    .eval_step  (eval_step),
    .x_at_min   (x_at_min),
    .y_min      (y_min),
    .iter_used  (iter_used),
    .converged  (converged),
    .busy       (busy),
    .done_op    (done_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Evaluator: mode 0 f=(x-3)^2 step=grad/4, mode 1 rising value fixed step,
  // mode 2 falling value with most-negative step.
  function automatic void eval_fn(input int mode, input logic [31:0] x, input int k,
                                  output logic [63:0] v, output logic [31:0] s);
    longint d;
    d = longint'($signed(x)) - 64'sd768;
    case (mode)
      0: begin v = 64'(d * d); s = 32'(d >>> 1); end
      1: begin v = 64'(100 + k); s = 32'h0000_1000; end
      default: begin v = 64'(-k); s = 32'h8000_0000; end
    endcase
  endfunction

  // Reference descent algorithm; pushes predicted points and final results.
  task automatic model_run(input logic [31:0] x0, input logic [7:0] mi,
                           input logic [31:0] eps, input int mode);
    longint x, sc, mag, nx, ymin;
    logic [63:0] v;
    logic [31:0] s;
    logic [31:0] xmin;
    int shift, iter, mi_eff;
    logic conv;
    res_t r;
    x = longint'($signed(x0));
    ymin = longint'(VMAX);
    xmin = x0; shift = 0; iter = 0; conv = 1'b0;
    mi_eff = (mi == 8'd0) ? 1 : int'(mi);
    for (int k = 0; k < 300; k++) begin
      exp_x_q.push_back(32'(x));
      eval_fn(mode, 32'(x), k, v, s);
      sc = longint'($signed(s)) >>> shift;
      if (longint'($signed(v)) < ymin) begin
        ymin = longint'($signed(v));
        xmin = 32'(x);
      end else if (iter > 0) begin
        shift = (shift < 7) ? shift + 1 : 7;
      end
      iter++;
      mag = (sc < 0) ? -sc : sc;
      if (mag < longint'(eps)) begin conv = 1'b1; break; end
      if (iter >= mi_eff) break;
      nx = x - sc;
      if (nx > 64'sh7FFF_FFFF) nx = 64'sh7FFF_FFFF;
      else if (nx < -64'sh8000_0000) nx = -64'sh8000_0000;
      x = nx;
    end
    r.x_at_min = xmin;
    r.y_min = 64'(ymin);
    r.iter_used = 8'(iter);
    r.converged = conv;
    exp_res_q.push_back(r);
  endtask

  // Run one operation to DONE, answering evaluator requests after ack_dly cycles.
  task automatic run_op(input string name, input logic [31:0] x0, input logic [7:0] mi,
                        input logic [31:0] eps, input int mode, input int ack_dly);
    res_t e;
    int k, cyc;
    bit fin;
    logic [63:0] v;
    logic [31:0] s, ex;
    obs_x_q.delete();
    model_run(x0, mi, eps, mode);
    @(negedge clk);
    x_init = x0; max_iter = mi; epsilon = eps; start_op = 1'b1;
    k = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (done_op === 1'b1) begin
        fin = 1'b1;
      end else if (eval_req === 1'b1) begin
        obs_x_q.push_back(eval_x);
        n_tests++;
        if (exp_x_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_eval: eval_x=%h, no request expected", name, eval_x);
        end else begin
          ex = exp_x_q.pop_front();
          if (eval_x !== ex) begin
            n_fail++;
            $display("FAIL %s eval_x[%0d]: got %h expected %h", name, k, eval_x, ex);
          end
        end
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk); cyc++;
          n_tests++;
          if (eval_req !== 1'b1 || eval_x !== obs_x_q[$]) begin
            n_fail++;
            $display("FAIL %s req_stable: eval_req=%b eval_x=%h expected 1 %h",
                     name, eval_req, eval_x, obs_x_q[$]);
          end
        end
        eval_fn(mode, eval_x, k, v, s);
        eval_ack = 1'b1; eval_value = v; eval_step = s;
        @(negedge clk); cyc++;
        eval_ack = 1'b0; k++;
        n_tests++;
        if (busy !== 1'b1 || eval_req !== 1'b0) begin
          n_fail++;
          $display("FAIL %s update_status: busy=%b eval_req=%b expected 1 0", name, busy, eval_req);
        end
      end
    end
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: done_op not seen within %0d cycles", name, cyc);
    end
    n_tests++;
    if (exp_x_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_evals: %0d predicted requests not issued", name, exp_x_q.size());
    end
    exp_x_q.delete();
    if (exp_res_q.size() > 0) begin
      e = exp_res_q.pop_front();
      n_tests++;
      if (x_at_min !== e.x_at_min) begin
        n_fail++;
        $display("FAIL %s x_at_min: got %h expected %h", name, x_at_min, e.x_at_min);
      end
      n_tests++;
      if (y_min !== e.y_min) begin
        n_fail++;
        $display("FAIL %s y_min: got %h expected %h", name, y_min, e.y_min);
      end
      n_tests++;
      if (iter_used !== e.iter_used) begin
        n_fail++;
        $display("FAIL %s iter_used: got %0d expected %0d", name, iter_used, e.iter_used);
      end
      n_tests++;
      if (converged !== e.converged) begin
        n_fail++;
        $display("FAIL %s converged: got %b expected %b", name, converged, e.converged);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || eval_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_status: busy=%b eval_req=%b expected 0 0", name, busy, eval_req);
    end
  endtask

  task automatic end_op(input string name);
    start_op = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done_op !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: done_op=%b busy=%b expected 0 0", name, done_op, busy);
    end
  endtask

  task automatic wait_req(input string name);
    int c;
    c = 0;
    while (eval_req !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    n_tests++;
    if (eval_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_req: eval_req=%b after %0d cycles, expected 1", name, eval_req, c);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_tests++;
    if (eval_req !== 1'b0 || eval_x !== 32'h0 || x_at_min !== 32'h0 || y_min !== 64'h0 ||
        iter_used !== 8'h0 || converged !== 1'b0 || busy !== 1'b0 || done_op !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: req=%b x=%h xmin=%h ymin=%h iter=%0d conv=%b busy=%b done=%b expected all 0",
               name, eval_req, eval_x, x_at_min, y_min, iter_used, converged, busy, done_op);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_ack_ignored();
    eval_ack = 1'b1;
    repeat (3) @(negedge clk);
    eval_ack = 1'b0;
    n_tests++;
    if (eval_req !== 1'b0 || busy !== 1'b0 || done_op !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack: req=%b busy=%b done=%b expected 0 0 0", eval_req, busy, done_op);
    end
  endtask

  task automatic test_converge();
    longint dx;
    run_op("converge", 32'h0000_0A00, 8'd50, 32'h0000_0001, 0, 0);
    dx = longint'($signed(x_at_min)) - 64'sd768;
    n_tests++;
    if (converged !== 1'b1 || done_op !== 1'b1 || dx < -1 || dx > 1) begin
      n_fail++;
      $display("FAIL converge_spec: conv=%b done=%b x_at_min=%h expected 1 1 0x300+-1",
               converged, done_op, x_at_min);
    end
    end_op("converge");
  endtask

  task automatic test_iter_limit();
    run_op("iter_limit", 32'h0000_0A00, 8'd3, 32'h0000_0001, 0, 0);
    n_tests++;
    if (iter_used !== 8'd3 || converged !== 1'b0 || obs_x_q.size() != 3 || done_op !== 1'b1) begin
      n_fail++;
      $display("FAIL iter_limit_spec: iter=%0d conv=%b evals=%0d done=%b expected 3 0 3 1",
               iter_used, converged, obs_x_q.size(), done_op);
    end
    end_op("iter_limit");
    run_op("max_iter_zero", 32'h0000_0A00, 8'd0, 32'h0000_0001, 0, 0);
    n_tests++;
    if (iter_used !== 8'd1 || obs_x_q.size() != 1) begin
      n_fail++;
      $display("FAIL max_iter_zero: iter=%0d evals=%0d expected 1 1", iter_used, obs_x_q.size());
    end
    end_op("max_iter_zero");
  endtask

  task automatic test_shift_damping();
    logic [31:0] d0, d1, dl;
    run_op("shift", 32'h0, 8'd12, 32'h0000_0001, 1, 1);
    n_tests++;
    if (obs_x_q.size() != 12) begin
      n_fail++;
      $display("FAIL shift_evals: got %0d expected 12", obs_x_q.size());
    end else begin
      d0 = obs_x_q[1] - obs_x_q[2];
      d1 = obs_x_q[2] - obs_x_q[3];
      dl = obs_x_q[10] - obs_x_q[11];
      if (d0 !== 32'h1000 || d1 !== 32'h800 || dl !== 32'h20) begin
        n_fail++;
        $display("FAIL shift_steps: deltas %h %h %h expected 1000 800 20", d0, d1, dl);
      end
    end
    end_op("shift");
  endtask

  task automatic test_saturate();
    run_op("saturate", 32'h7FFF_FF00, 8'd2, 32'h0000_0001, 2, 0);
    n_tests++;
    if (obs_x_q.size() != 2 || obs_x_q[$] !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL saturate_x: evals=%0d last eval_x=%h expected 2 7fffffff",
               obs_x_q.size(), obs_x_q[$]);
    end
    end_op("saturate");
  endtask

  task automatic test_abort();
    logic [63:0] v;
    logic [31:0] s, held;
    @(negedge clk);
    x_init = 32'h0000_0A00; max_iter = 8'd50; epsilon = 32'h1; start_op = 1'b1;
    @(negedge clk);
    wait_req("abort_first");
    eval_fn(0, eval_x, 0, v, s);
    eval_ack = 1'b1; eval_value = v; eval_step = s;
    @(negedge clk);
    eval_ack = 1'b0;
    @(negedge clk);
    wait_req("abort_second");
    held = eval_x;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (eval_req !== 1'b1 || eval_x !== held) begin
        n_fail++;
        $display("FAIL abort_hold[%0d]: req=%b x=%h expected 1 %h", c, eval_req, eval_x, held);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (done_op !== 1'b1 || converged !== 1'b0 || busy !== 1'b0 || eval_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_status: done=%b conv=%b busy=%b req=%b expected 1 0 0 0",
               done_op, converged, busy, eval_req);
    end
    n_tests++;
    if (x_at_min !== 32'h0000_0A00 || y_min !== 64'h0031_0000 || iter_used !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_best: xmin=%h ymin=%h iter=%0d expected 00000a00 0000000000310000 1",
               x_at_min, y_min, iter_used);
    end
    end_op("abort");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    x_init = 32'h0000_0A00; max_iter = 8'd50; epsilon = 32'h1; start_op = 1'b1;
    @(negedge clk);
    wait_req("rst_mid");
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_mid_eval");
    start_op = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 32'h0000_0A00, 8'd50, 32'h0000_0001, 0, 0);
    end_op("after_reset");
  endtask

  initial begin
    test_reset();
    test_ack_ignored();
    test_converge();
    test_iter_limit();
    test_shift_damping();
    test_saturate();
    test_abort();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
